ws2812b_stream_sequencer: RTL and testbench

WS2812B_STREAM_SEQUENCER -- requirements
Module: ws2812b_stream_sequencer

---
 rtl/ws2812b_stream_sequencer.sv | 159 +++++++++++++++
 tb/tb_ws2812b_stream_sequencer.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ws2812b_stream_sequencer.sv
// Queues {colour, count, latch} commands and plays each one out as a run of
// identical pixels toward a WS2812B serializer, one pixel per ready window.
module ws2812b_stream_sequencer #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [23:0] cmd_color,
    input  logic [5:0]  cmd_count,
    input  logic        cmd_latch,
    input  logic        flush,
    output logic [23:0] pix_data,
    output logic        pix_valid,
    output logic        pix_latch,
    input  logic        pix_ready,
    output logic        busy,
    output logic [3:0]  level,
    output logic        done
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [3:0] DEPTH_L = 4'(FIFO_DEPTH);

    typedef struct packed {
        logic [23:0] color;
        logic [5:0]  count;
        logic        latch;
    } cmd_t;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ISSUE,
        HOLD
    } state_t;

    cmd_t          mem_q [FIFO_DEPTH];
    cmd_t          head;
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [3:0]    level_q, level_d;
    logic          full, empty, push, pop;

    state_t        state_q, state_d;
    logic [6:0]    rem_q, rem_d;
    logic [23:0]   data_q, data_d;
    logic          clatch_q, clatch_d;
    logic          abort_q, abort_d;

    assign full      = (level_q == DEPTH_L);
    assign empty     = (level_q == 4'd0);
    assign cmd_ready = !full && !flush;
    assign push      = cmd_valid && cmd_ready;
    assign head      = mem_q[rd_ptr_q];
    assign level_d   = level_q + {3'b000, push} - {3'b000, pop};

    assign pix_data  = data_q;
    assign level     = level_q;
    assign busy      = (state_q != IDLE) || !empty;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= '{color: cmd_color, count: cmd_count, latch: cmd_latch};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            level_q <= level_d;
        end
    end

    // A flush seen during ISSUE still passes through HOLD, so remember it.
    assign abort_d = (state_q == ISSUE) && flush;

    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        data_d    = data_q;
        clatch_d  = clatch_q;
        pop       = 1'b0;
        done      = 1'b0;
        pix_valid = 1'b0;
        pix_latch = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!flush && !empty) begin
                    pop     = 1'b1;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (flush) begin
                    state_d = IDLE;
                    rem_d   = '0;
                end else if (pix_ready) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                pix_valid = 1'b1;
                pix_latch = (rem_q == 7'd1) && clatch_q;
                state_d   = HOLD;
            end
            HOLD: begin
                if (flush || abort_q) begin
                    state_d = IDLE;
                    rem_d   = '0;
                end else if (rem_q > 7'd1) begin
                    rem_d   = rem_q - 7'd1;
                    state_d = WAIT;
                end else begin
                    done  = 1'b1;
                    rem_d = '0;
                    if (!empty) begin
                        pop     = 1'b1;
                        state_d = WAIT;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (pop) begin
            data_d   = head.color;
            rem_d    = {1'b0, head.count} + 7'd1;
            clatch_d = head.latch;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            rem_q    <= '0;
            data_q   <= '0;
            clatch_q <= 1'b0;
            abort_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            rem_q    <= rem_d;
            data_q   <= data_d;
            clatch_q <= clatch_d;
            abort_q  <= abort_d;
        end
    end

endmodule

// File: tb/tb_ws2812b_stream_sequencer.sv
// Directed bench for ws2812b_stream_sequencer: latency, backpressure,
// long runs, flush, async reset and FIFO wrap ordering.
module tb_ws2812b_stream_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [23:0] cmd_color;
    logic [5:0]  cmd_count;
    logic        cmd_latch;
    logic        flush;
    logic [23:0] pix_data;
    logic        pix_valid;
    logic        pix_latch;
    logic        pix_ready;
    logic        busy;
    logic [3:0]  level;
    logic        done;

    logic ser_mode = 1'b0;
    logic rdy_force = 1'b0;
    int   ser_cnt = 0;

    int n_tests = 0;
    int n_fail = 0;

    int          n_valid = 0;
    int          n_latch = 0;
    int          n_done = 0;
    int          n_b2b = 0;
    int          latch_idx = 0;
    logic        prev_v = 1'b0;
    logic [23:0] col_q[$];

    always #5 clk = ~clk;

    ws2812b_stream_sequencer #(.FIFO_DEPTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_color (cmd_color),
        .cmd_count (cmd_count),
        .cmd_latch (cmd_latch),
        .flush     (flush),
        .pix_data  (pix_data),
        .pix_valid (pix_valid),
        .pix_latch (pix_latch),
        .pix_ready (pix_ready),
        .busy      (busy),
        .level     (level),
        .done      (done)
    );

    // Serializer model: goes busy for 10 cycles after every pixel push.
    assign pix_ready = ser_mode ? (ser_cnt == 0) : rdy_force;

    always @(negedge clk) begin
        if (pix_valid) ser_cnt <= 10;
        else if (ser_cnt != 0) ser_cnt <= ser_cnt - 1;
    end

    always @(negedge clk) begin
        if (pix_valid) begin
            n_valid = n_valid + 1;
            col_q.push_back(pix_data);
            if (pix_latch) begin
                n_latch = n_latch + 1;
                latch_idx = n_valid;
            end
            if (prev_v) n_b2b = n_b2b + 1;
        end
        if (done) n_done = n_done + 1;
        prev_v = pix_valid;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [23:0] c, input logic [5:0] n, input logic l);
        int k;
        cmd_valid = 1'b1;
        cmd_color = c;
        cmd_count = n;
        cmd_latch = l;
        k = 0;
        #0;
        while (!cmd_ready && k < 300) begin
            tick(1);
            k++;
        end
        chk("push_timeout", 32'(k < 300), 1);
        tick(1);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int bound);
        int k;
        k = 0;
        while (busy && k < bound) begin
            tick(1);
            k++;
        end
        chk(tag, 32'(busy), 0);
    endtask

    initial begin
        int v0, d0, l0, c0;
        logic [23:0] exp_c[$];

        rst_n = 1'b0;
        cmd_valid = 1'b0;
        cmd_color = '0;
        cmd_count = '0;
        cmd_latch = 1'b0;
        flush = 1'b0;

        #12;
        chk("rst_level", 32'(level), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_valid", 32'(pix_valid), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_data", 32'(pix_data), 0);
        chk("rst_ready", 32'(cmd_ready), 1);
        rst_n = 1'b1;
        tick(2);

        // single command, 3 pixels, latch on the last one, serializer model
        ser_mode = 1'b1;
        v0 = n_valid; d0 = n_done; l0 = n_latch;
        push(24'h00FF00, 6'd2, 1'b1);
        chk("lat_c1", 32'(pix_valid), 0);
        tick(1);
        chk("lat_c2", 32'(pix_valid), 0);
        tick(1);
        chk("lat_c3_valid", 32'(pix_valid), 1);
        chk("lat_c3_latch", 32'(pix_latch), 0);
        tick(1);
        chk("one_cycle_valid", 32'(pix_valid), 0);
        wait_idle("t1_idle", 200);
        chk("t1_nvalid", 32'(n_valid - v0), 3);
        chk("t1_nlatch", 32'(n_latch - l0), 1);
        chk("t1_latch_idx", 32'(latch_idx - v0), 3);
        chk("t1_ndone", 32'(n_done - d0), 1);
        chk("t1_col0", 32'(col_q[v0]), 32'h00FF00);
        chk("t1_col2", 32'(col_q[v0+2]), 32'h00FF00);

        // back-to-back commands into a stalled serializer
        ser_mode = 1'b0;
        rdy_force = 1'b0;
        exp_c = {24'h110001, 24'h220002, 24'h330003, 24'h440004, 24'h550005, 24'h660006};
        c0 = col_q.size(); d0 = n_done;
        cmd_valid = 1'b1;
        cmd_count = 6'd0;
        cmd_latch = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cmd_color = exp_c[i];
            tick(1);
        end
        chk("full_level", 32'(level), 4);
        chk("full_ready", 32'(cmd_ready), 0);
        chk("full_hold_data", 32'(pix_data), 32'h110001);
        cmd_color = exp_c[5];
        tick(3);
        chk("full_stays", 32'(level), 4);
        rdy_force = 1'b1;
        begin
            int k;
            k = 0;
            while (!cmd_ready && k < 50) begin
                tick(1);
                k++;
            end
            chk("pop_timeout", 32'(k < 50), 1);
        end
        chk("after_pop_level", 32'(level), 3);
        tick(1);
        chk("sixth_accepted", 32'(level), 4);
        cmd_valid = 1'b0;
        wait_idle("t2_idle", 200);
        chk("t2_ndone", 32'(n_done - d0), 6);
        for (int i = 0; i < 6; i++) chk("t2_order", 32'(col_q[c0+i]), 32'(exp_c[i]));

        // 64-pixel run without latch
        v0 = n_valid; d0 = n_done; l0 = n_latch;
        push(24'hABCDEF, 6'd63, 1'b0);
        wait_idle("t3_idle", 500);
        chk("t3_nvalid", 32'(n_valid - v0), 64);
        chk("t3_nlatch", 32'(n_latch - l0), 0);
        chk("t3_ndone", 32'(n_done - d0), 1);

        // flush in HOLD of pixel 2 of 5, two commands queued
        rdy_force = 1'b0;
        d0 = n_done;
        push(24'h0A0A0A, 6'd4, 1'b1);
        push(24'h0B0B0B, 6'd0, 1'b0);
        push(24'h0C0C0C, 6'd0, 1'b0);
        chk("t4_queued", 32'(level), 2);
        rdy_force = 1'b1;
        begin
            int k, seen;
            k = 0;
            seen = 0;
            while (seen < 2 && k < 50) begin
                tick(1);
                k++;
                if (pix_valid) seen++;
            end
            chk("t4_pix2_timeout", 32'(seen), 2);
        end
        tick(1);
        flush = 1'b1;
        cmd_valid = 1'b1;
        cmd_color = 24'h0D0D0D;
        #1;
        chk("flush_blocks_ready", 32'(cmd_ready), 0);
        tick(1);
        flush = 1'b0;
        cmd_valid = 1'b0;
        chk("flush_level", 32'(level), 0);
        chk("flush_busy", 32'(busy), 0);
        v0 = n_valid;
        tick(10);
        chk("flush_no_valid", 32'(n_valid - v0), 0);
        chk("flush_no_done", 32'(n_done - d0), 0);

        // async reset while in WAIT with three queued
        rdy_force = 1'b0;
        for (int i = 0; i < 4; i++) push(24'h123400 + 24'(i), 6'd0, 1'b0);
        chk("t5_queued", 32'(level), 3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_level", 32'(level), 0);
        chk("arst_busy", 32'(busy), 0);
        chk("arst_data", 32'(pix_data), 0);
        chk("arst_valid", 32'(pix_valid), 0);
        chk("arst_done", 32'(done), 0);
        tick(1);
        rst_n = 1'b1;
        chk("arst_ready", 32'(cmd_ready), 1);
        rdy_force = 1'b1;
        push(24'h5A5A5A, 6'd0, 1'b0);
        tick(1);
        chk("post_rst_c2", 32'(pix_valid), 0);
        tick(1);
        chk("post_rst_valid", 32'(pix_valid), 1);
        chk("post_rst_data", 32'(pix_data), 32'h5A5A5A);
        wait_idle("t5_idle", 50);

        // simultaneous push/pop at level 2, then wrap over 10 commands
        rdy_force = 1'b0;
        exp_c = {24'hA00001, 24'hA00002, 24'hA00003, 24'hA00004};
        for (int i = 0; i < 10; i++) exp_c.push_back(24'hB00000 + 24'(i * 17));
        c0 = col_q.size();
        for (int i = 0; i < 3; i++) push(exp_c[i], 6'd0, 1'b0);
        chk("t6_level2", 32'(level), 2);
        rdy_force = 1'b1;
        tick(2);
        chk("t6_hold_level", 32'(level), 2);
        cmd_valid = 1'b1;
        cmd_color = exp_c[3];
        cmd_count = 6'd0;
        cmd_latch = 1'b0;
        tick(1);
        chk("pushpop_level", 32'(level), 2);
        cmd_valid = 1'b0;
        for (int i = 4; i < 14; i++) push(exp_c[i], 6'd0, 1'b0);
        wait_idle("t6_idle", 300);
        chk("t6_npix", 32'(col_q.size() - c0), 14);
        for (int i = 0; i < 14; i++) chk("wrap_order", 32'(col_q[c0+i]), 32'(exp_c[i]));

        chk("no_b2b_valid", 32'(n_b2b), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
